// File: rtl/fwd_source_pipe.sv
// EXE/MEM/WB control and result registers feeding the ID-stage forwarding muxes,
// with bubble insertion on stall/flush and saturating stall/retire counters.
module fwd_source_pipe #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             id_wmem,
    input  logic [RW-1:0]    id_rn,
    input  logic [DW-1:0]    exe_alu,
    input  logic [DW-1:0]    mem_rdata,
    output logic             exe_wreg,
    output logic             exe_m2reg,
    output logic             exe_wmem,
    output logic [RW-1:0]    exe_rn,
    output logic [DW-1:0]    exe_result,
    output logic             mem_wreg,
    output logic             mem_m2reg,
    output logic             mem_wmem,
    output logic [RW-1:0]    mem_rn,
    output logic [DW-1:0]    mem_result,
    output logic [DW-1:0]    mem_mo,
    output logic             wb_wreg,
    output logic [RW-1:0]    wb_rn,
    output logic [DW-1:0]    wdi,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic            ev_r, exe_wreg_r, exe_m2reg_r, exe_wmem_r;
    logic [RW-1:0]   exe_rn_r;
    logic            mv_r, mem_wreg_r, mem_m2reg_r, mem_wmem_r;
    logic [RW-1:0]   mem_rn_r;
    logic [DW-1:0]   mem_alu_r;
    logic            wv_r, wb_wreg_r, wb_m2reg_r;
    logic [RW-1:0]   wb_rn_r;
    logic [DW-1:0]   wb_alu_r, wb_mo_r;
    logic [CNT_W-1:0] stall_cnt_r, retire_cnt_r;
    logic            rn_zero_s;

    assign rn_zero_s = (id_rn == {RW{1'b0}});

    // ID/EXE register: bubble on stall or flush; a write to x0 is dropped at entry
    always_ff @(posedge clk) begin
        if (rst || stall || flush) begin
            ev_r        <= 1'b0;
            exe_wreg_r  <= 1'b0;
            exe_m2reg_r <= 1'b0;
            exe_wmem_r  <= 1'b0;
            exe_rn_r    <= {RW{1'b0}};
        end else begin
            ev_r        <= 1'b1;
            exe_wreg_r  <= id_wreg & ~rn_zero_s;
            exe_m2reg_r <= id_m2reg;
            exe_wmem_r  <= id_wmem;
            exe_rn_r    <= id_rn;
        end
    end

    // EXE/MEM register
    always_ff @(posedge clk) begin
        if (rst) begin
            mv_r        <= 1'b0;
            mem_wreg_r  <= 1'b0;
            mem_m2reg_r <= 1'b0;
            mem_wmem_r  <= 1'b0;
            mem_rn_r    <= {RW{1'b0}};
            mem_alu_r   <= {DW{1'b0}};
        end else begin
            mv_r        <= ev_r;
            mem_wreg_r  <= exe_wreg_r;
            mem_m2reg_r <= exe_m2reg_r;
            mem_wmem_r  <= exe_wmem_r;
            mem_rn_r    <= exe_rn_r;
            mem_alu_r   <= exe_alu;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk) begin
        if (rst) begin
            wv_r       <= 1'b0;
            wb_wreg_r  <= 1'b0;
            wb_m2reg_r <= 1'b0;
            wb_rn_r    <= {RW{1'b0}};
            wb_alu_r   <= {DW{1'b0}};
            wb_mo_r    <= {DW{1'b0}};
        end else begin
            wv_r       <= mv_r;
            wb_wreg_r  <= mem_wreg_r;
            wb_m2reg_r <= mem_m2reg_r;
            wb_rn_r    <= mem_rn_r;
            wb_alu_r   <= mem_alu_r;
            wb_mo_r    <= mem_rdata;
        end
    end

    // Saturating performance counters; reset has priority over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            retire_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r  <= stall ? sat_inc(stall_cnt_r) : stall_cnt_r;
            retire_cnt_r <= wv_r ? sat_inc(retire_cnt_r) : retire_cnt_r;
        end
    end

    assign exe_wreg   = ev_r & exe_wreg_r;
    assign exe_m2reg  = ev_r & exe_m2reg_r;
    assign exe_wmem   = ev_r & exe_wmem_r;
    assign exe_rn     = exe_rn_r;
    assign exe_result = exe_alu;
    assign mem_wreg   = mv_r & mem_wreg_r;
    assign mem_m2reg  = mv_r & mem_m2reg_r;
    assign mem_wmem   = mv_r & mem_wmem_r;
    assign mem_rn     = mem_rn_r;
    assign mem_result = mem_alu_r;
    assign mem_mo     = mem_rdata;
    assign wb_wreg    = wv_r & wb_wreg_r;
    assign wb_rn      = wb_rn_r;
    assign wdi        = wb_m2reg_r ? wb_mo_r : wb_alu_r;
    assign stall_cnt  = stall_cnt_r;
    assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Directed bench for fwd_source_pipe; counters built 2 bits wide so saturation is reachable.
module tb_fwd_source_pipe;

    localparam int DW = 32, RW = 5, CNT_W = 2;

    logic clk = 1'b0;
    logic rst, stall, flush, id_wreg, id_m2reg, id_wmem;
    logic [RW-1:0] id_rn;
    logic [DW-1:0] exe_alu, mem_rdata;
    logic exe_wreg, exe_m2reg, exe_wmem, mem_wreg, mem_m2reg, mem_wmem, wb_wreg;
    logic [RW-1:0] exe_rn, mem_rn, wb_rn;
    logic [DW-1:0] exe_result, mem_result, mem_mo, wdi;
    logic [CNT_W-1:0] stall_cnt, retire_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_source_pipe #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_rn(id_rn),
        .exe_alu(exe_alu), .mem_rdata(mem_rdata),
        .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem), .exe_rn(exe_rn),
        .exe_result(exe_result),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem), .mem_rn(mem_rn),
        .mem_result(mem_result), .mem_mo(mem_mo),
        .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wdi(wdi),
        .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic m2, input logic wm, input logic [RW-1:0] rn);
        stall = 1'b0; flush = 1'b0;
        id_wreg = wr; id_m2reg = m2; id_wmem = wm; id_rn = rn;
    endtask

    task automatic idle();
        stall = 1'b0; flush = 1'b1;
        id_wreg = 1'b0; id_m2reg = 1'b0; id_wmem = 1'b0; id_rn = 5'd0;
    endtask

    initial begin
        rst = 1'b1; exe_alu = 32'd0; mem_rdata = 32'd0;
        idle();
        tick(); tick();
        rst = 1'b0;

        // 1: reset state and combinational pass-throughs
        check_val("rst_exe_wreg", 32'(exe_wreg), 32'd0);
        check_val("rst_mem_wreg", 32'(mem_wreg), 32'd0);
        check_val("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        check_val("rst_exe_rn", 32'(exe_rn), 32'd0);
        check_val("rst_wdi", wdi, 32'd0);
        check_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check_val("rst_retire_cnt", 32'(retire_cnt), 32'd0);
        exe_alu = 32'hCAFE; mem_rdata = 32'hBEEF;
        #1;
        check_val("exe_result_pass", exe_result, 32'hCAFE);
        check_val("mem_mo_pass", mem_mo, 32'hBEEF);
        exe_alu = 32'd0; mem_rdata = 32'd0;

        // 2: ALU op to r5
        issue(1'b1, 1'b0, 1'b0, 5'd5);
        tick();
        check_val("alu_exe_rn", 32'(exe_rn), 32'd5);
        check_val("alu_exe_wreg", 32'(exe_wreg), 32'd1);
        exe_alu = 32'h1234; idle();
        tick();
        check_val("alu_mem_rn", 32'(mem_rn), 32'd5);
        check_val("alu_mem_result", mem_result, 32'h1234);
        check_val("alu_mem_wreg", 32'(mem_wreg), 32'd1);
        check_val("alu_exe_bubble", 32'(exe_wreg), 32'd0);
        exe_alu = 32'd0;
        tick();
        check_val("alu_wb_wreg", 32'(wb_wreg), 32'd1);
        check_val("alu_wb_rn", 32'(wb_rn), 32'd5);
        check_val("alu_wdi", wdi, 32'h1234);
        check_val("alu_retire_pre", 32'(retire_cnt), 32'd0);
        tick();
        check_val("alu_retire", 32'(retire_cnt), 32'd1);
        check_val("alu_wb_drained", 32'(wb_wreg), 32'd0);

        // 3: load to r7 followed by one load-use stall cycle
        issue(1'b1, 1'b1, 1'b0, 5'd7);
        tick();
        check_val("ld_exe_m2reg", 32'(exe_m2reg), 32'd1);
        check_val("ld_exe_rn", 32'(exe_rn), 32'd7);
        stall = 1'b1; flush = 1'b0; id_wreg = 1'b0; id_m2reg = 1'b0; id_rn = 5'd9;
        tick();
        check_val("ld_mem_m2reg", 32'(mem_m2reg), 32'd1);
        check_val("ld_mem_rn", 32'(mem_rn), 32'd7);
        check_val("ld_exe_wreg_bubble", 32'(exe_wreg), 32'd0);
        check_val("ld_exe_rn_bubble", 32'(exe_rn), 32'd0);
        check_val("ld_stall_cnt", 32'(stall_cnt), 32'd1);
        idle(); mem_rdata = 32'hDEAD;
        tick();
        check_val("ld_wdi", wdi, 32'hDEAD);
        check_val("ld_wb_wreg", 32'(wb_wreg), 32'd1);
        check_val("ld_wb_rn", 32'(wb_rn), 32'd7);
        mem_rdata = 32'd0;
        tick();
        check_val("ld_retire", 32'(retire_cnt), 32'd2);
        check_val("ld_stall_hold", 32'(stall_cnt), 32'd1);

        // 4: write to x0 is dropped
        issue(1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        check_val("x0_exe_wreg", 32'(exe_wreg), 32'd0);
        check_val("x0_exe_rn", 32'(exe_rn), 32'd0);
        idle();
        tick();
        check_val("x0_mem_wreg", 32'(mem_wreg), 32'd0);
        tick();
        check_val("x0_wb_wreg", 32'(wb_wreg), 32'd0);
        tick();
        check_val("x0_retire", 32'(retire_cnt), 32'd3);

        // 5: flushed store never enables memory; unflushed store does
        issue(1'b0, 1'b0, 1'b1, 5'd0);
        flush = 1'b1;
        tick();
        check_val("fl_exe_wmem", 32'(exe_wmem), 32'd0);
        issue(1'b0, 1'b0, 1'b1, 5'd0);
        tick();
        check_val("fl_mem_wmem", 32'(mem_wmem), 32'd0);
        check_val("st_exe_wmem", 32'(exe_wmem), 32'd1);
        idle();
        tick();
        check_val("st_mem_wmem", 32'(mem_wmem), 32'd1);
        tick(); tick();
        check_val("retire_sat", 32'(retire_cnt), 32'd3);

        // 6: reset with all stages full, then stall saturation
        issue(1'b1, 1'b0, 1'b0, 5'd1);
        tick();
        issue(1'b1, 1'b0, 1'b0, 5'd2);
        tick();
        issue(1'b1, 1'b0, 1'b0, 5'd3);
        tick();
        check_val("full_wb_rn", 32'(wb_rn), 32'd1);
        check_val("full_mem_rn", 32'(mem_rn), 32'd2);
        check_val("full_exe_rn", 32'(exe_rn), 32'd3);
        rst = 1'b1; stall = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 5'd4);
        stall = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rr_exe_wreg", 32'(exe_wreg), 32'd0);
        check_val("rr_exe_rn", 32'(exe_rn), 32'd0);
        check_val("rr_mem_wreg", 32'(mem_wreg), 32'd0);
        check_val("rr_mem_rn", 32'(mem_rn), 32'd0);
        check_val("rr_wb_wreg", 32'(wb_wreg), 32'd0);
        check_val("rr_wb_rn", 32'(wb_rn), 32'd0);
        check_val("rr_stall_cnt", 32'(stall_cnt), 32'd0);
        check_val("rr_retire_cnt", 32'(retire_cnt), 32'd0);
        issue(1'b1, 1'b0, 1'b0, 5'd6);
        stall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_val($sformatf("sat_stall_cnt_%0d", k), 32'(stall_cnt), (k > 3) ? 32'd3 : 32'(k));
            check_val($sformatf("sat_exe_wreg_%0d", k), 32'(exe_wreg), 32'd0);
        end
        idle();
        tick();
        check_val("sat_stall_hold", 32'(stall_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
